// File: rtl/bs_pkg.sv
// bs_pkg: shared state encoding, Q16.16 format and operand-slice offsets for the Black-Scholes scheduler
package bs_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
    localparam int FBITS  = 16;
    localparam int OFF_S0 = 4;
    localparam int OFF_K  = 3;
    localparam int OFF_T  = 2;
    localparam int OFF_SG = 1;
    localparam int OFF_R  = 0;
endpackage

// File: rtl/bs_rr_arbiter.sv
// bs_rr_arbiter: combinational round-robin pick of the first request at or after i_ptr (i_req/i_ptr in; o_gnt one-hot, o_id, o_any out)
module bs_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_id,
    output logic            o_any
);
    logic [IDW-1:0] w_idx;
    always_comb begin
        o_any = 1'b0;
        o_id  = '0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_idx]) begin
                o_any = 1'b1;
                o_id  = w_idx;
            end
        end
        o_gnt = o_any ? (NREQ'(1) << o_id) : '0;
    end
endmodule

// File: rtl/bs_engine_scheduler.sv
// bs_engine_scheduler: round-robin sharing of one d1/d2 engine; req_* job handshake in, eng_* engine drive/return, rsp_* tagged result out, busy; optional BS_SCHED_TIMEOUT_EN WAIT watchdog
module bs_engine_scheduler
    import bs_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*5*WIDTH-1:0] req_ops,
    output logic                    eng_start,
    output logic [WIDTH-1:0]        eng_S0,
    output logic [WIDTH-1:0]        eng_K,
    output logic [WIDTH-1:0]        eng_T,
    output logic [WIDTH-1:0]        eng_sigma,
    output logic [WIDTH-1:0]        eng_r,
    input  logic                    eng_done,
    input  logic [WIDTH-1:0]        eng_d1,
    input  logic [WIDTH-1:0]        eng_d2,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_d1,
    output logic [WIDTH-1:0]        rsp_d2,
    output logic                    rsp_err,
    output logic                    busy
);
    state_t             r_state, w_next;
    logic [IDW-1:0]     r_ptr, r_id, w_gid;
    logic [NREQ-1:0]    w_gnt;
    logic               w_any, w_to, w_fin;
    logic [5*WIDTH-1:0] w_ops;

    bs_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_id  (w_gid),
        .o_any (w_any)
    );

    assign w_ops     = req_ops[int'(w_gid)*5*WIDTH +: 5*WIDTH];
    assign req_ready = (r_state == IDLE) ? w_gnt : '0;
    assign eng_start = r_state == ISSUE;
    assign rsp_valid = r_state == RESP;
    assign busy      = r_state != IDLE;
    assign rsp_id    = r_id;
    assign w_fin     = (r_state == WAIT) && (eng_done || w_to);

`ifdef BS_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] r_cnt;
    // counter is zero whenever not in WAIT, so it starts from 0 on each entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
    end
    assign w_to = (r_state == WAIT) && (r_cnt == CW'(TIMEOUT - 1));
`else
    assign w_to = 1'b0 & (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // eng_done outside WAIT (including the ISSUE cycle) never advances the FSM
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_fin ? RESP : WAIT;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr     <= '0;
            r_id      <= '0;
            eng_S0    <= '0;
            eng_K     <= '0;
            eng_T     <= '0;
            eng_sigma <= '0;
            eng_r     <= '0;
            rsp_d1    <= '0;
            rsp_d2    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_id      <= w_gid;
                r_ptr     <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);
                eng_S0    <= w_ops[OFF_S0*WIDTH +: WIDTH];
                eng_K     <= w_ops[OFF_K*WIDTH +: WIDTH];
                eng_T     <= w_ops[OFF_T*WIDTH +: WIDTH];
                eng_sigma <= w_ops[OFF_SG*WIDTH +: WIDTH];
                eng_r     <= w_ops[OFF_R*WIDTH +: WIDTH];
            end
            // a real result wins over a timeout in the same cycle
            if (w_fin) begin
                rsp_d1  <= eng_done ? eng_d1 : '0;
                rsp_d2  <= eng_done ? eng_d2 : '0;
                rsp_err <= !eng_done;
            end
        end
    end
endmodule

// File: tb/tb_bs_engine_scheduler.sv
// tb_bs_engine_scheduler: directed + randomized checks of the scheduler against a round-robin/engine reference model
module tb_bs_engine_scheduler;
    import bs_pkg::*;
    localparam int W = 32;
    localparam int N = 4;
`ifdef BS_SCHED_TIMEOUT_EN
    localparam int TO = 16;
    localparam int SJ_LAT = 12;
`else
    localparam int TO = 1024;
    localparam int SJ_LAT = 40;
`endif

    logic clk = 0, reset = 1;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*5*W-1:0] req_ops;
    logic eng_start, eng_done = 0, rsp_valid, rsp_ready = 0, rsp_err, busy;
    logic [W-1:0] eng_S0, eng_K, eng_T, eng_sigma, eng_r, eng_d1 = '0, eng_d2 = '0, rsp_d1, rsp_d2;
    logic [1:0] rsp_id;
    logic [5*W-1:0] ops [N];
    int tests = 0, fails = 0, ptr = 0, g;

    for (genvar k = 0; k < N; k++) assign req_ops[k*5*W +: 5*W] = ops[k];

    always #5 clk = ~clk;

    bs_engine_scheduler #(.WIDTH(W), .NREQ(N), .IDW(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_ops(req_ops),
        .eng_start(eng_start), .eng_S0(eng_S0), .eng_K(eng_K), .eng_T(eng_T), .eng_sigma(eng_sigma),
        .eng_r(eng_r), .eng_done(eng_done), .eng_d1(eng_d1), .eng_d2(eng_d2), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_d1(rsp_d1), .rsp_d2(rsp_d2), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference round robin: first valid requester at or after the priority pointer
    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int k = 0; k < N; k++) ops[k] = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    endtask

    // one complete job, called and returning at a negedge with the DUT idle
    task automatic do_job(input logic [N-1:0] v, input int lat, input int bp, input bit spur, input bit fixed, output int go);
        logic [5*W-1:0] o;
        logic [W-1:0] e1, e2;
        req_valid = v;
        #1;
        go = rr(v, ptr);
        chk("req_ready_grant", req_ready, 4'b1 << go);
        chk("req_ready_onehot", 64'($countones(req_ready) <= 1), 1);
        o = ops[go];
        e1 = fixed ? 32'h0000_5999 : o[159:128] + o[31:0];
        e2 = fixed ? 32'h0000_2666 : o[127:96] ^ o[95:64];
        @(posedge clk);
        ptr = (go + 1) % N;
        @(negedge clk);
        chk("eng_start_issue", eng_start, 1);
        chk("eng_S0", eng_S0, o[159:128]);
        chk("eng_r", eng_r, o[31:0]);
        chk("ready_busy", req_ready, 0);
        if (spur) begin eng_done = 1; eng_d1 = '1; eng_d2 = '1; end
        @(negedge clk);
        eng_done = 0;
        chk("eng_start_once", eng_start, 0);
        chk("no_early_rsp", rsp_valid, 0);
        for (int i = 1; i < lat; i++) @(negedge clk);
        chk("eng_K_held", eng_K, o[127:96]);
        eng_done = 1;
        eng_d1 = fixed ? 32'h0000_5999 : eng_S0 + eng_r;
        eng_d2 = fixed ? 32'h0000_2666 : eng_K ^ eng_T;
        @(negedge clk);
        eng_done = 0; eng_d1 = $urandom; eng_d2 = $urandom;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, go);
        chk("rsp_d1", rsp_d1, e1);
        chk("rsp_d2", rsp_d2, e2);
        chk("rsp_err", rsp_err, 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_d1", rsp_d1, e1);
            chk("bp_id", rsp_id, go);
            chk("bp_no_ready", req_ready, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_drop", rsp_valid, 0);
        chk("idle", busy, 0);
    endtask

    initial begin
        rand_ops();
        repeat (2) @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_S0", eng_S0, 0);
        chk("rst_d1", rsp_d1, 0);
        reset = 0;
        @(negedge clk);
        eng_done = 1;
        @(negedge clk);
        eng_done = 0;
        chk("spur_idle_valid", rsp_valid, 0);
        chk("spur_idle_busy", busy, 0);
        for (int j = 0; j < 8; j++) begin
            do_job(4'b1111, 3, 0, 0, 0, g);
            chk("fair_order", g, j % N);
        end
        ops[2] = {32'(100 << FBITS), 32'(100 << FBITS), 32'(1 << FBITS), 32'h0000_3333, 32'h0000_0CCD};
        do_job(4'b0100, SJ_LAT, 0, 0, 1, g);
        rand_ops();
        do_job(4'b1011, 5, 10, 1, 0, g);
        for (int j = 0; j < 20; j++) begin
            rand_ops();
            do_job(4'($urandom_range(1, 15)), $urandom_range(1, 8), $urandom_range(0, 3), 1'($urandom), 0, g);
        end
        req_valid = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        reset = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_S0", eng_S0, 0);
        chk("midrst_valid", rsp_valid, 0);
        @(negedge clk);
        reset = 0;
        ptr = 0;
        @(negedge clk);
        chk("midrst_no_rsp", rsp_valid, 0);
        do_job(4'b1010, 4, 1, 0, 0, g);
        chk("post_rst_id", g, 1);
        req_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
`ifdef BS_SCHED_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            chk("to_wait", rsp_valid, 0);
        end
        @(negedge clk);
        chk("to_valid", rsp_valid, 1);
        chk("to_err", rsp_err, 1);
        chk("to_d1", rsp_d1, 0);
        chk("to_d2", rsp_d2, 0);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("to_idle", busy, 0);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("no_to_busy", busy, 1);
        end
        chk("no_to_valid", rsp_valid, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
